// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;
   localparam int DATA_W      = 32;
   localparam int DEF_TIMEOUT = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Saturating WAIT-cycle counter. expired looks at the value the counter is about to take,
// so it fires on the TIMEOUT-th counted cycle.
module mem_wait_timer
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (clr)
         cnt_next = '0;
      else if (en && cnt != CW'(TIMEOUT))
         cnt_next = cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_next;
   end

   assign expired = (cnt_next == CW'(TIMEOUT));
endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-slow-RAM access controller: IDLE -> WAIT (until ack or timeout) -> DONE (one cycle).
// Holds the request stable on the RAM side and reports read data or a timeout error.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   output logic                  cpu_err,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout,
   input  logic                  ram_ack
);
   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [DATA_W-1:0]     hold_wdata;
   logic                  hold_we;
   logic [DATA_W-1:0]     rdata_q;
   logic                  err_q;
   logic                  accept, tmr_en, expired, timed_out;

   assign accept    = (state == IDLE) && cpu_req;
   assign tmr_en    = (state == WAIT) && !ram_ack;
   // ack has priority: a timeout only counts on a cycle without ack
   assign timed_out = tmr_en && expired;

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (tmr_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cpu_req) state_next = WAIT;
         WAIT:    if (ram_ack || expired) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_we    <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            hold_addr  <= cpu_addr;
            hold_wdata <= cpu_wdata;
            hold_we    <= cpu_we;
         end
         if ((state == WAIT) && ram_ack && !hold_we)
            rdata_q <= ram_dout;
         else if (timed_out)
            rdata_q <= '0;
         // set only on the edge into DONE, so it is a single-cycle pulse there
         err_q <= timed_out;
      end
   end

   always_comb begin
      ram_cs   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = cpu_addr;
      case (state)
         WAIT: begin
            ram_cs   = 1'b1;
            ram_we   = hold_we;
            ram_addr = hold_addr;
         end
         // inverted address breaks the RAM's same-address run between back-to-back accesses
         DONE:    ram_addr = ~hold_addr;
         default: ram_addr = cpu_addr;
      endcase
   end

   assign ram_din   = hold_wdata;
   assign cpu_stall = cpu_req && (state != DONE);
   assign cpu_rdata = rdata_q;
   assign cpu_err   = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random transactions
// against a slow-RAM model and a transaction-level expectation model.
module tb_mem_access_ctrl;
   localparam int TO = 31;

   logic        clk = 1'b0;
   logic        rst, cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall, cpu_err, ram_cs, ram_we;
   logic [31:0] ram_addr, ram_din;
   logic [31:0] ram_dout = 32'h0;
   logic        ram_ack  = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .cpu_err   (cpu_err),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .ram_ack   (ram_ack)
   );

   // Slow RAM: acks once cs has been high on the same address for ram_delay cycles (0 = never)
   int          ram_delay = 0;
   int          stable    = 0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] mem [16]  = '{default: 32'h0};

   always @(negedge clk) begin
      int s;
      s = (ram_cs && ram_addr == prev_addr && stable > 0) ? stable + 1 : (ram_cs ? 1 : 0);
      stable    <= s;
      prev_addr <= ram_addr;
      ram_ack   <= ram_cs && ram_delay != 0 && s == ram_delay;
      ram_dout  <= mem[ram_addr[3:0]];
      if (ram_cs && ram_we && ram_delay != 0 && s == ram_delay)
         mem[ram_addr[3:0]] <= ram_din;
   end

   // Expectation model
   logic [31:0] exp_mem [16] = '{default: 32'h0};
   logic [31:0] exp_rdata    = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic txn(input logic we, input logic [3:0] a, input logic [31:0] wd,
                      input int d, input bit drop);
      int          n;
      int          exp_n;
      bit          exp_err;
      logic [31:0] exp_rd;
      logic [31:0] addr32;
      addr32  = {28'h0, a};
      exp_err = (d == 0 || d > TO);
      exp_n   = exp_err ? TO : d;
      exp_rd  = exp_err ? 32'h0 : (we ? exp_rdata : exp_mem[a]);

      @(posedge clk) #1;
      ram_delay = d;
      chk("idle_cs", {31'h0, ram_cs}, 32'h0);
      chk("idle_err", {31'h0, cpu_err}, 32'h0);
      chk("rdata_hold", cpu_rdata, exp_rdata);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr32; cpu_wdata = wd;
      #1;
      chk("idle_stall", {31'h0, cpu_stall}, 32'h1);
      chk("idle_addr", ram_addr, addr32);

      n = 0;
      @(posedge clk) #1;
      while (ram_cs === 1'b1 && n < 100) begin
         n++;
         chk("wait_addr", ram_addr, addr32);
         chk("wait_we", {31'h0, ram_we}, {31'h0, we});
         if (we) chk("wait_din", ram_din, wd);
         chk("wait_stall", {31'h0, cpu_stall}, {31'h0, cpu_req});
         chk("wait_err", {31'h0, cpu_err}, 32'h0);
         if (drop) cpu_req = 1'b0;
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         cpu_we    = ~we;
         @(posedge clk) #1;
      end

      chk("wait_cycles", n, exp_n);
      chk("done_stall", {31'h0, cpu_stall}, 32'h0);
      chk("done_err", {31'h0, cpu_err}, {31'h0, exp_err});
      chk("done_rdata", cpu_rdata, exp_rd);
      chk("done_addr", ram_addr, ~addr32);
      chk("done_we", {31'h0, ram_we}, 32'h0);
      cpu_req = 1'b0;
      exp_rdata = exp_rd;
      if (we && !exp_err) exp_mem[a] = wd;
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_err", {31'h0, cpu_err}, 32'h0);
      chk("rst_cs", {31'h0, ram_cs}, 32'h0);
      chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
      rst = 1'b0;

      // read of 0x4 returning 0xDEADBEEF after 8 cycles
      txn(1'b1, 4'h4, 32'hDEADBEEF, 3, 1'b0);
      txn(1'b0, 4'h4, 32'h0, 8, 1'b0);
      // write then read back 0x3
      txn(1'b1, 4'h3, 32'h12345678, 5, 1'b0);
      txn(1'b0, 4'h3, 32'h0, 4, 1'b0);
      // back-to-back reads of the same address each see the full delay
      txn(1'b1, 4'h5, 32'hA5A5_0F0F, 2, 1'b0);
      txn(1'b0, 4'h5, 32'h0, 6, 1'b0);
      txn(1'b0, 4'h5, 32'h0, 6, 1'b0);
      // never acked: timeout, error pulse, rdata cleared
      txn(1'b0, 4'h5, 32'h0, 0, 1'b0);
      // ack on the timeout cycle wins
      txn(1'b0, 4'h4, 32'h0, TO, 1'b0);
      // ack one cycle too late: timed-out write, not stored
      txn(1'b1, 4'h6, 32'h0BAD_F00D, TO + 1, 1'b0);
      txn(1'b0, 4'h6, 32'h0, 1, 1'b0);
      // request dropped during WAIT still completes
      txn(1'b0, 4'h3, 32'h0, 7, 1'b1);

      // reset during WAIT cycle 3
      @(posedge clk) #1;
      ram_delay = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7; cpu_wdata = 32'h1111_2222;
      repeat (3) @(posedge clk);
      #1;
      chk("rstw_cs_before", {31'h0, ram_cs}, 32'h1);
      rst = 1'b1;
      @(posedge clk) #1;
      chk("rstw_cs", {31'h0, ram_cs}, 32'h0);
      chk("rstw_we", {31'h0, ram_we}, 32'h0);
      chk("rstw_idle_addr", ram_addr, cpu_addr);
      chk("rstw_rdata", cpu_rdata, 32'h0);
      chk("rstw_err", {31'h0, cpu_err}, 32'h0);
      rst = 1'b0; cpu_req = 1'b0;
      exp_rdata = 32'h0;
      @(posedge clk) #1;
      chk("rstw_err2", {31'h0, cpu_err}, 32'h0);
      chk("rstw_cs2", {31'h0, ram_cs}, 32'h0);
      chk("rstw_stall2", {31'h0, cpu_stall}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         int d;
         d = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, TO + 4);
         txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, d,
             $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
